// File: rtl/div_share_pkg.sv
// Shared constants for the time-shared divider controller: FSM encoding and operand width.
package div_share_pkg;

  localparam int OP_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/div_rr_arb.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap, returns one-hot grant and index.
module div_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    logic            found;
    int unsigned     c;
    logic [ID_W-1:0] ci;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c  = (32'(ptr) + k) % 32'(N_REQ);
      ci = ID_W'(c);
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin time-sharing controller for one external combinational signed divider.
// Optional macro DIV_SHARE_ERR_EN adds rsp_err (divide-by-zero / -128/-1 overflow flag).
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [OP_W*N_REQ-1:0] req_dividend,
  input  logic [OP_W*N_REQ-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [OP_W-1:0]       rsp_quotient,
  output logic [OP_W-1:0]       rsp_remainder,
  output logic                  busy,
  output logic [OP_W-1:0]       div_dividend,
  output logic [OP_W-1:0]       div_divisor,
  input  logic [OP_W-1:0]       div_quotient,
  input  logic [OP_W-1:0]       div_remainder
`ifdef DIV_SHARE_ERR_EN
  ,
  output logic                  rsp_err
`endif
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [OP_W-1:0]  opa_q, opa_d;
  logic [OP_W-1:0]  opb_q, opb_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [OP_W-1:0]  rsp_quot_q, rsp_quot_d;
  logic [OP_W-1:0]  rsp_rem_q, rsp_rem_d;
`ifdef DIV_SHARE_ERR_EN
  logic             rsp_err_q, rsp_err_d;
`endif

  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic [OP_W-1:0]  win_a, win_b;

  div_rr_arb #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == arb_idx) begin
        win_a = req_dividend[i*OP_W +: OP_W];
        win_b = req_divisor[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
`ifdef DIV_SHARE_ERR_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          opa_d   = win_a;
          opb_d   = win_b;
          id_d    = arb_idx;
          ptr_d   = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_quot_d  = div_quotient;
          rsp_rem_d   = div_remainder;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
`ifdef DIV_SHARE_ERR_EN
          rsp_err_d   = (opb_q == '0) || (opa_q == 8'h80 && opb_q == 8'hFF);
`endif
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
`ifdef DIV_SHARE_ERR_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
`ifdef DIV_SHARE_ERR_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready     = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign busy          = (state_q != ST_IDLE);
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
`ifdef DIV_SHARE_ERR_EN
  assign rsp_err       = rsp_err_q;
`endif

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural signed divider on the div_* ports.
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_quotient;
  logic [7:0]  rsp_remainder;
  logic        busy;
  logic [7:0]  div_dividend;
  logic [7:0]  div_divisor;
  logic [7:0]  div_quotient;
  logic [7:0]  div_remainder;
`ifdef DIV_SHARE_ERR_EN
  logic        rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(
    .N_REQ (4),
    .ID_W  (2),
    .SETTLE(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .busy         (busy),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
`ifdef DIV_SHARE_ERR_EN
    ,
    .rsp_err      (rsp_err)
`endif
  );

  // Behavioural shared divider: truncating, 0/0 on divide-by-zero, 127/0 on -128/-1.
  logic signed [7:0] da, db;
  assign da = div_dividend;
  assign db = div_divisor;
  always_comb begin
    if (db == 8'sh00) begin
      div_quotient  = 8'h00;
      div_remainder = 8'h00;
    end else if (da == 8'sh80 && db == 8'shFF) begin
      div_quotient  = 8'h7F;
      div_remainder = 8'h00;
    end else begin
      div_quotient  = da / db;
      div_remainder = da % db;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    req_dividend[id*8 +: 8] = a;
    req_divisor[id*8 +: 8]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    int          q;
    int          r;
    int          err;
  } vec_t;

  task automatic do_txn(input vec_t v);
    int n;
    req_valid = '0;
    set_ops(v.id, v.a, v.b);
    req_valid[v.id] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 20) begin tick(); n++; end
    chk("txn_grant", int'(req_ready), 1 << v.id);
    tick();
    req_valid = '0;
    #1;
    chk("txn_ready_pulse", int'(req_ready), 0);
    chk("txn_busy", int'(busy), 1);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("txn_latency", n, 2);
    chk("txn_id", int'(rsp_id), v.id);
    chk("txn_q", int'($signed(rsp_quotient)), v.q);
    chk("txn_r", int'($signed(rsp_remainder)), v.r);
`ifdef DIV_SHARE_ERR_EN
    chk("txn_err", int'(rsp_err), v.err);
`endif
    tick();
    chk("txn_rsp_drop", int'(rsp_valid), 0);
    chk("txn_idle", int'(busy), 0);
  endtask

  int ord[4];
  int at[4];

  task automatic rr_run(input logic [3:0] start, input int ng_exp);
    int cyc;
    int ng;
    logic [3:0] last;
    req_valid = start;
    rsp_ready = 1'b1;
    cyc = 0;
    ng = 0;
    while (ng < ng_exp && cyc < 60) begin
      #1;
      last = req_ready;
      if (last != 4'b0) begin
        chk("rr_onehot", $countones(last), 1);
        for (int i = 0; i < 4; i++) if (last[i]) ord[ng] = i;
        at[ng] = cyc;
        ng++;
      end
      @(posedge clk);
      #1;
      cyc++;
      req_valid = req_valid & ~last;
    end
    chk("rr_grant_count", ng, ng_exp);
    cyc = 0;
    while (busy && cyc < 20) begin tick(); cyc++; end
    chk("rr_drain", int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2, 8'd100, 8'd7,   14,  2, 0};
    vecs[1] = '{1, 8'hCE,  8'd3,  -16, -2, 0};
    vecs[2] = '{0, 8'd55,  8'd0,    0,  0, 1};
    vecs[3] = '{3, 8'h80,  8'hFF, 127,  0, 1};
    vecs[4] = '{2, 8'd20,  8'd4,    5,  0, 0};
    vecs[5] = '{1, 8'hF9,  8'd2,   -3, -1, 0};
    vecs[6] = '{0, 8'd127, 8'hFD, -42,  1, 0};

    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_q", int'(rsp_quotient), 0);
    chk("reset_r", int'(rsp_remainder), 0);
    chk("reset_div_a", int'(div_dividend), 0);
    chk("reset_div_b", int'(div_divisor), 0);
    chk("reset_ready", int'(req_ready), 0);
`ifdef DIV_SHARE_ERR_EN
    chk("reset_err", int'(rsp_err), 0);
`endif

    // Round robin from reset: all four contend, pointer starts at 0.
    for (int i = 0; i < 4; i++) set_ops(i, 8'(10 * (i + 1)), 8'd3);
    rr_run(4'b1111, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", ord[i], i);
    for (int i = 0; i < 3; i++) chk("rr_spacing", at[i+1] - at[i], 4);
    rr_run(4'b1001, 2);
    chk("rr_wrap_first", ord[0], 0);
    chk("rr_wrap_second", ord[1], 3);

    for (int unsigned k = 0; k < 7; k++) do_txn(vecs[k]);

    // Backpressure: response held while consumer stalls, no new grant meanwhile.
    begin
      int n;
      logic [3:0] pend;
      req_valid = '0;
      set_ops(1, 8'hCE, 8'd3);
      set_ops(0, 8'd9, 8'd1);
      req_valid[1] = 1'b1;
      rsp_ready = 1'b0;
      #1;
      pend = req_ready;
      chk("bp_grant", int'(pend), 2);
      tick();
      req_valid = 4'b0001;
      n = 0;
      while (!rsp_valid && n < 20) begin
        tick(); n++;
      end
      chk("bp_latency", n, 2);
      for (int i = 0; i < 10; i++) begin
        chk("bp_valid_hold", int'(rsp_valid), 1);
        chk("bp_q_hold", int'($signed(rsp_quotient)), -16);
        chk("bp_r_hold", int'($signed(rsp_remainder)), -2);
        chk("bp_id_hold", int'(rsp_id), 1);
        chk("bp_ready_low", int'(req_ready), 0);
        tick();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      tick();
      chk("bp_release_valid", int'(rsp_valid), 0);
      chk("bp_release_idle", int'(busy), 0);
      chk("bp_keep_q", int'($signed(rsp_quotient)), -16);
    end

    // Reset during SETTLE: accept from req 1, then pointer would be 2 without reset.
    begin
      req_valid = '0;
      set_ops(1, 8'd9, 8'd2);
      req_valid[1] = 1'b1;
      #1;
      chk("rst_mid_grant", int'(req_ready), 2);
      tick();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_valid", int'(rsp_valid), 0);
      chk("rst_mid_div_a", int'(div_dividend), 0);
      chk("rst_mid_div_b", int'(div_divisor), 0);
      chk("rst_mid_q", int'(rsp_quotient), 0);
      chk("rst_mid_r", int'(rsp_remainder), 0);
      chk("rst_mid_id", int'(rsp_id), 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("rst_mid_no_rsp", int'(rsp_valid), 0);
      end
      set_ops(1, 8'd9, 8'd2);
      set_ops(3, 8'd8, 8'd2);
      req_valid = 4'b1010;
      #1;
      chk("rst_mid_ptr0", int'(req_ready), 2);
      req_valid = '0;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
